pwm_peripheral: RTL

Downstream consumer of the SPI register file. Takes the five configuration bytes (output enables, PWM enables, duty cycle) and drives 16 output pins. Each pin is held low, driven high, or driven by a shared 8-bit PWM waveform. Duty-cycle updates are double-buffered so they apply only at a period boundary, which keeps the waveform glitch-free.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_prescaler.sv | 29 ++
 rtl/pwm_peripheral.sv | 76 +++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, types and channel-drive helpers for the PWM output block.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam int unsigned NUM_CH    = 16;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;
    typedef logic [NUM_CH-1:0]    ch_mask_t;

    localparam pwm_cnt_t DUTY_FULL = 8'hFF;

    // Full-scale duty is solid high; everything else is duty/256 high time.
    function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
    endfunction

    // Disabled channels are low; enabled static channels are high; PWM channels follow pwm_raw.
    function automatic ch_mask_t channel_drive(input ch_mask_t en_out, input ch_mask_t en_pwm,
                                               input logic pwm_raw);
        return en_out & (~en_pwm | {NUM_CH{pwm_raw}});
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: emits a one-cycle tick every PRESCALE clk cycles.
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 12
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

    logic [CntW-1:0] pre_q, pre_d;

    assign tick = (pre_q == Last);

    always_comb begin
        pre_d = tick ? '0 : pre_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each pin is low, high, or the shared PWM waveform,
// with the duty cycle double-buffered onto the period boundary.
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    ch_mask_t en_out, en_pwm;
    logic     tick, wrap, pwm_raw;

    pwm_cnt_t cnt_q, cnt_d;
    pwm_cnt_t duty_shadow_q, duty_shadow_d;
    logic     period_start_q, period_start_d;
    logic     first_q;
    ch_mask_t pwm_out_q, pwm_out_d;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign wrap = tick && (cnt_q == '1);

    always_comb begin
        cnt_d         = cnt_q;
        duty_shadow_d = duty_shadow_q;
        if (tick) begin
            cnt_d = cnt_q + pwm_cnt_t'(1);
        end
        // Duty is only taken on the last step of a period so the waveform never glitches.
        if (wrap) begin
            duty_shadow_d = pwm_duty_cycle;
        end
        // first_q marks the first cycle out of reset, which also opens a period.
        period_start_d = wrap | first_q;
        pwm_raw        = pwm_level(cnt_q, duty_shadow_q);
        pwm_out_d      = channel_drive(en_out, en_pwm, pwm_raw);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            duty_shadow_q  <= '0;
            period_start_q <= 1'b0;
            first_q        <= 1'b1;
            pwm_out_q      <= '0;
        end else begin
            cnt_q          <= cnt_d;
            duty_shadow_q  <= duty_shadow_d;
            period_start_q <= period_start_d;
            first_q        <= 1'b0;
            pwm_out_q      <= pwm_out_d;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule
